// File: rtl/bimodal_pht.sv
// -----------------------------------------------------------------------------
// bimodal_pht
//   Pattern history table for a bimodal branch predictor: 2^INDEX_WIDTH
//   two-bit saturating counters. One prediction lookup and one resolved-branch
//   update are serviced every cycle. Updates go through a two-stage
//   read-modify-write pipeline: U1 captures the entry, U2 writes the
//   saturated next value back. After reset, an init sweep writes INIT_VALUE
//   to every entry. Lookups and updates are ignored until the sweep is done.
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   rst_n           : asynchronous active-low reset
//   pred_valid      : lookup request (accepted whenever the table is running)
//   pred_index      : entry to look up
//   pred_resp_valid : registered strobe, one cycle after an accepted lookup
//   pred_counter    : counter value returned by the last accepted lookup
//   pred_taken      : MSB of pred_counter
//   upd_valid       : update request
//   upd_index       : entry to update
//   upd_taken       : branch outcome (1 = increment, 0 = decrement)
//   upd_ready       : high once the table accepts updates
//   init_done       : high once the init sweep has completed
// -----------------------------------------------------------------------------
module bimodal_pht #(
  parameter int         INDEX_WIDTH = 6,
  parameter logic [1:0] INIT_VALUE  = 2'b01
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pred_valid,
  input  logic [INDEX_WIDTH-1:0] pred_index,
  output logic                   pred_resp_valid,
  output logic [1:0]             pred_counter,
  output logic                   pred_taken,
  input  logic                   upd_valid,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  input  logic                   upd_taken,
  output logic                   upd_ready,
  output logic                   init_done
);

  localparam int                     ENTRIES    = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = {INDEX_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH-1:0] PTR_STEP   = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 2-bit saturating counter step; never wraps in either direction.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      if (cnt == 2'b11) begin
        nxt = cnt;
      end else begin
        nxt = cnt + 2'b01;
      end
    end else begin
      if (cnt == 2'b00) begin
        nxt = cnt;
      end else begin
        nxt = cnt - 2'b01;
      end
    end
    return nxt;
  endfunction

  state_t                 state_r;
  logic [INDEX_WIDTH-1:0] init_ptr_r;
  logic [1:0]             table_r [ENTRIES];

  logic                   u1_valid_r;
  logic [INDEX_WIDTH-1:0] u1_index_r;
  logic                   u1_taken_r;
  logic [1:0]             u1_counter_r;

  logic                   lookup_accept_s;
  logic                   upd_accept_s;
  logic                   wb_en_s;
  logic [1:0]             wb_value_s;
  logic [1:0]             pred_read_s;
  logic [1:0]             upd_read_s;

  // Write-back value for the entry held in U1; also the bypass source.
  always_comb begin
    wb_en_s    = u1_valid_r;
    wb_value_s = sat_next(u1_counter_r, u1_taken_r);
  end

  // Request acceptance: nothing gets in while the init sweep is running.
  always_comb begin
    lookup_accept_s = pred_valid && (state_r == ST_RUN);
    upd_accept_s    = upd_valid && upd_ready;
  end

  // Table reads with write-first bypass: a write landing at this edge wins.
  always_comb begin
    if (wb_en_s && (u1_index_r == pred_index)) begin
      pred_read_s = wb_value_s;
    end else begin
      pred_read_s = table_r[pred_index];
    end
    if (wb_en_s && (u1_index_r == upd_index)) begin
      upd_read_s = wb_value_s;
    end else begin
      upd_read_s = table_r[upd_index];
    end
  end

  // Init sweep / run-mode FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_ptr_r <= {INDEX_WIDTH{1'b0}};
      init_done  <= 1'b0;
      upd_ready  <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_ptr_r <= init_ptr_r + PTR_STEP;
          if (init_ptr_r == LAST_INDEX) begin
            state_r   <= ST_RUN;
            init_done <= 1'b1;
            upd_ready <= 1'b1;
          end else begin
            state_r   <= ST_INIT;
            init_done <= 1'b0;
            upd_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          state_r   <= ST_RUN;
          init_done <= 1'b1;
          upd_ready <= 1'b1;
        end
        default: begin
          state_r    <= ST_INIT;
          init_ptr_r <= {INDEX_WIDTH{1'b0}};
          init_done  <= 1'b0;
          upd_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Counter storage: sweep writes during INIT, U2 write-back in RUN.
  // Left unreset on purpose; the sweep establishes every entry after reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      table_r[init_ptr_r] <= INIT_VALUE;
    end else if (wb_en_s) begin
      table_r[u1_index_r] <= wb_value_s;
    end
  end

  // U1 stage: capture the update and the (bypassed) current counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1_valid_r   <= 1'b0;
      u1_index_r   <= {INDEX_WIDTH{1'b0}};
      u1_taken_r   <= 1'b0;
      u1_counter_r <= 2'b00;
    end else begin
      u1_valid_r <= upd_accept_s;
      if (upd_accept_s) begin
        u1_index_r   <= upd_index;
        u1_taken_r   <= upd_taken;
        u1_counter_r <= upd_read_s;
      end
    end
  end

  // Lookup response register; counter holds its last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_resp_valid <= 1'b0;
      pred_counter    <= 2'b00;
      pred_taken      <= 1'b0;
    end else begin
      pred_resp_valid <= lookup_accept_s;
      if (lookup_accept_s) begin
        pred_counter <= pred_read_s;
        pred_taken   <= pred_read_s[1];
      end
    end
  end

endmodule

// File: tb/tb_bimodal_pht.sv
module tb_bimodal_pht;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pred_valid = 1'b0;
  logic [5:0] pred_index = 6'd0;
  logic       pred_resp_valid;
  logic [1:0] pred_counter;
  logic       pred_taken;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_index = 6'd0;
  logic       upd_taken = 1'b0;
  logic       upd_ready;
  logic       init_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bimodal_pht #(.INDEX_WIDTH(6), .INIT_VALUE(2'b01)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_valid      (pred_valid),
    .pred_index      (pred_index),
    .pred_resp_valid (pred_resp_valid),
    .pred_counter    (pred_counter),
    .pred_taken      (pred_taken),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_taken       (upd_taken),
    .upd_ready       (upd_ready),
    .init_done       (init_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pred_valid = 1'b0;
    pred_index = 6'd0;
    upd_valid  = 1'b0;
    upd_index  = 6'd0;
    upd_taken  = 1'b0;
  endtask

  // Reset, release, and wait out the 64-cycle sweep (no checks).
  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (64) step();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (pred_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", pred_resp_valid); end
    checks++; if (pred_counter !== 2'b00) begin failures++; $display("FAIL reset_counter got=%b exp=00", pred_counter); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
    checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL reset_upd_ready got=%b exp=0", upd_ready); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    step();
    step();
    rst_n = 1'b1;
    // Traffic during the sweep must be ignored.
    pred_valid = 1'b1; pred_index = 6'd3;
    upd_valid  = 1'b1; upd_index  = 6'd3; upd_taken = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      checks++;
      if (pred_resp_valid !== 1'b0) begin
        failures++; $display("FAIL init_ignore_lookup cycle=%0d got=%b exp=0", i, pred_resp_valid);
      end
      if (i < 64) begin
        checks++;
        if (init_done !== 1'b0 || upd_ready !== 1'b0) begin
          failures++; $display("FAIL init_early_done cycle=%0d got=%b%b exp=00", i, init_done, upd_ready);
        end
      end else begin
        checks++;
        if (init_done !== 1'b1 || upd_ready !== 1'b1) begin
          failures++; $display("FAIL init_done_rise cycle=%0d got=%b%b exp=11", i, init_done, upd_ready);
        end
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_init_values();
    logic [5:0] idxs [4] = '{6'd0, 6'd31, 6'd63, 6'd3};
    for (int i = 0; i < 4; i++) begin
      pred_valid = 1'b1; pred_index = idxs[i];
      step();
      pred_valid = 1'b0;
      checks++;
      if (pred_resp_valid !== 1'b1 || pred_counter !== 2'b01 || pred_taken !== 1'b0) begin
        failures++;
        $display("FAIL init_value idx=%0d got v=%b c=%b t=%b exp v=1 c=01 t=0", idxs[i], pred_resp_valid, pred_counter, pred_taken);
      end
      step();
      checks++;
      if (pred_resp_valid !== 1'b0 || pred_counter !== 2'b01) begin
        failures++;
        $display("FAIL idle_hold idx=%0d got v=%b c=%b exp v=0 c=01", idxs[i], pred_resp_valid, pred_counter);
      end
    end
  endtask

  task automatic test_sat_up();
    logic [1:0] exp [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1; upd_index = 6'd5; upd_taken = 1'b1;
      step();
      upd_valid = 1'b0;
      pred_valid = 1'b1; pred_index = 6'd5;
      step();
      pred_valid = 1'b0;
      checks++;
      if (pred_resp_valid !== 1'b1 || pred_counter !== exp[i] || pred_taken !== 1'b1) begin
        failures++;
        $display("FAIL sat_up step=%0d got v=%b c=%b t=%b exp v=1 c=%b t=1", i, pred_resp_valid, pred_counter, pred_taken, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_sat_down();
    upd_valid = 1'b1; upd_index = 6'd5; upd_taken = 1'b0;
    repeat (5) step();
    upd_valid = 1'b0;
    pred_valid = 1'b1; pred_index = 6'd5;
    step();
    checks++;
    if (pred_counter !== 2'b00 || pred_taken !== 1'b0) begin
      failures++; $display("FAIL sat_down got c=%b t=%b exp c=00 t=0", pred_counter, pred_taken);
    end
    step();
    pred_valid = 1'b0;
    checks++;
    if (pred_counter !== 2'b00) begin
      failures++; $display("FAIL sat_down_hold got c=%b exp c=00", pred_counter);
    end
    step();
  endtask

  task automatic test_forwarding();
    upd_valid = 1'b1; upd_index = 6'd9; upd_taken = 1'b1;
    step();                              // edge N
    pred_valid = 1'b1; pred_index = 6'd9;
    step();                              // edge N+1: second update + lookup
    upd_valid = 1'b0;
    checks++;
    if (pred_resp_valid !== 1'b1 || pred_counter !== 2'b10 || pred_taken !== 1'b1) begin
      failures++; $display("FAIL fwd_same_edge got v=%b c=%b t=%b exp v=1 c=10 t=1", pred_resp_valid, pred_counter, pred_taken);
    end
    step();                              // edge N+2
    pred_valid = 1'b0;
    checks++;
    if (pred_resp_valid !== 1'b1 || pred_counter !== 2'b11) begin
      failures++; $display("FAIL fwd_accumulate got v=%b c=%b exp v=1 c=11", pred_resp_valid, pred_counter);
    end
    step();
  endtask

  task automatic test_concurrent();
    logic [1:0] model [64];
    logic [1:0] inc_tbl [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [1:0] dec_tbl [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic       pend_v;
    logic [5:0] pend_idx;
    logic [1:0] pend_val;
    logic [1:0] exp_c;
    logic       pv, uv, ut;
    logic [5:0] pi, ui;
    apply_reset();
    for (int k = 0; k < 64; k++) model[k] = 2'b01;
    pend_v = 1'b0; pend_idx = 6'd0; pend_val = 2'b00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      pv = 1'($urandom_range(0, 1));
      uv = 1'($urandom_range(0, 1));
      ut = 1'($urandom_range(0, 1));
      pi = 6'($urandom_range(0, 15));
      ui = 6'($urandom_range(0, 15));
      pred_valid = pv; pred_index = pi;
      upd_valid = uv; upd_index = ui; upd_taken = ut;
      step();
      // Model the edge: the pending write commits first, then reads happen.
      if (pend_v) model[pend_idx] = pend_val;
      exp_c = model[pi];
      pend_v = uv;
      if (uv) begin
        pend_idx = ui;
        pend_val = ut ? inc_tbl[model[ui]] : dec_tbl[model[ui]];
      end
      checks++;
      if (pred_resp_valid !== pv) begin
        failures++; $display("FAIL rand_resp_valid cyc=%0d got=%b exp=%b", cyc, pred_resp_valid, pv);
      end
      if (pv) begin
        checks++;
        if (pred_counter !== exp_c || pred_taken !== exp_c[1]) begin
          failures++; $display("FAIL rand_counter cyc=%0d idx=%0d got c=%b t=%b exp c=%b", cyc, pi, pred_counter, pred_taken, exp_c);
        end
      end
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    upd_valid = 1'b1; upd_index = 6'd3; upd_taken = 1'b1;
    repeat (3) step();
    pred_valid = 1'b1; pred_index = 6'd3;
    step();                              // U1 now holds index 3, counter 11
    checks++;
    if (pred_resp_valid !== 1'b1 || pred_counter !== 2'b11) begin
      failures++; $display("FAIL mid_precond got v=%b c=%b exp v=1 c=11", pred_resp_valid, pred_counter);
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pred_resp_valid !== 1'b0 || pred_counter !== 2'b00 || pred_taken !== 1'b0 ||
        upd_ready !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got v=%b c=%b t=%b r=%b d=%b exp all zero",
               pred_resp_valid, pred_counter, pred_taken, upd_ready, init_done);
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (63) step();
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL mid_sweep_len got=%b exp=0", init_done);
    end
    step();
    checks++;
    if (init_done !== 1'b1 || upd_ready !== 1'b1) begin
      failures++; $display("FAIL mid_sweep_done got=%b%b exp=11", init_done, upd_ready);
    end
    pred_valid = 1'b1; pred_index = 6'd3;
    step();
    pred_valid = 1'b0;
    checks++;
    if (pred_resp_valid !== 1'b1 || pred_counter !== 2'b01 || pred_taken !== 1'b0) begin
      failures++; $display("FAIL mid_reinit got v=%b c=%b t=%b exp v=1 c=01 t=0", pred_resp_valid, pred_counter, pred_taken);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_sat_up();
    test_sat_down();
    test_forwarding();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
